// File: rtl/idft_sig_check.sv
// rtl/idft_sig_check.sv - MISR response compactor for the IDFT self-test flow
// Folds Y0..Y3 of NUM_VECTORS frames into a 64-bit signature and checks it against GOLDEN_SIG.
module idft_sig_check #(
  parameter int          FRAME_CYCLES = 2,
  parameter int          NUM_VECTORS  = 64,
  parameter int          TIMEOUT      = 255,
  parameter logic [63:0] GOLDEN_SIG   = 64'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        next_out,
  input  logic [15:0] Y0,
  input  logic [15:0] Y1,
  input  logic [15:0] Y2,
  input  logic [15:0] Y3,
  output logic [63:0] signature,
  output logic [15:0] vec_count,
  output logic        done,
  output logic        pass,
  output logic        timeout,
  output logic        frame_err
);

  typedef enum logic [1:0] {IDLE, CAPTURE, DONE} state_t;

  localparam logic [15:0] LAST_CYC = 16'(FRAME_CYCLES - 1);
  localparam logic [15:0] NUM_VEC  = 16'(NUM_VECTORS);
  localparam logic [31:0] WD_LAST  = 32'(TIMEOUT - 1);

  state_t      state, state_n;
  logic [15:0] frame_cnt, frame_cnt_n;
  logic [31:0] wdog, wdog_n;
  logic [63:0] sig_n, misr;
  logic [15:0] vec_n;
  logic        done_n, pass_n, timeout_n, frame_err_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      frame_cnt <= '0;
      wdog      <= '0;
      signature <= '0;
      vec_count <= '0;
      done      <= 1'b0;
      pass      <= 1'b0;
      timeout   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_n;
      frame_cnt <= frame_cnt_n;
      wdog      <= wdog_n;
      signature <= sig_n;
      vec_count <= vec_n;
      done      <= done_n;
      pass      <= pass_n;
      timeout   <= timeout_n;
      frame_err <= frame_err_n;
    end
  end

  // Next MISR value, computed every cycle but only committed on a valid capture.
  always_comb begin
    misr = {signature[62:0],
            signature[63] ^ signature[62] ^ signature[60] ^ signature[59]}
           ^ {Y0, Y1, Y2, Y3};
  end

  always_comb begin
    state_n     = state;
    frame_cnt_n = frame_cnt;
    wdog_n      = wdog;
    sig_n       = signature;
    vec_n       = vec_count;
    done_n      = done;
    pass_n      = pass;
    timeout_n   = timeout;
    frame_err_n = frame_err;

    case (state)
      IDLE: begin
        if (next_out) begin
          state_n     = CAPTURE;
          frame_cnt_n = '0;
          wdog_n      = '0;
        end else if (wdog == WD_LAST) begin
          state_n   = DONE;
          timeout_n = 1'b1;
          done_n    = 1'b1;
          pass_n    = 1'b0;
        end else begin
          wdog_n = wdog + 32'd1;
        end
      end

      CAPTURE: begin
        // next_out on the last capture cycle is a legal back-to-back frame, not an error.
        if (next_out && (frame_cnt != LAST_CYC)) begin
          frame_err_n = 1'b1;
          frame_cnt_n = '0;
        end else begin
          sig_n = misr;
          if (frame_cnt == LAST_CYC) begin
            vec_n       = vec_count + 16'd1;
            frame_cnt_n = '0;
            wdog_n      = '0;
            if (vec_n == NUM_VEC) begin
              state_n = DONE;
              done_n  = 1'b1;
              pass_n  = (misr == GOLDEN_SIG) && !frame_err;
            end else if (next_out) begin
              state_n = CAPTURE;
            end else begin
              state_n = IDLE;
            end
          end else begin
            frame_cnt_n = frame_cnt + 16'd1;
          end
        end
      end

      DONE: begin
        state_n = DONE;
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

endmodule
